// File: rtl/cdb_arbiter.sv
// Completion-bus arbiter: picks up to two FU results per cycle in round-robin order
// and registers them onto the two CDB slots; squash drops the broadcast and stalls grants.
module cdb_arbiter #(
    parameter int NUM_FU      = 4,
    parameter int XLEN        = 32,
    parameter int ROB_IDX_LEN = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  logic [NUM_FU*ROB_IDX_LEN-1:0] fu_rob_idx,
    input  logic [NUM_FU*XLEN-1:0]        fu_value,
    input  logic [NUM_FU-1:0]             fu_wrong_pred,
    output logic [NUM_FU-1:0]             fu_ready,
    output logic [1:0]                    cdb_valid,
    output logic [2*ROB_IDX_LEN-1:0]      cdb_rob_idx,
    output logic [2*XLEN-1:0]             cdb_value,
    output logic [1:0]                    cdb_wrong_pred,
    output logic [$clog2(NUM_FU)-1:0]     rr_ptr
);

    localparam int              PTR_W   = $clog2(NUM_FU);
    localparam logic [PTR_W:0]  FU_CNT  = (PTR_W+1)'(NUM_FU);
    localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);

    // Modular add with an explicit wrap compare so non-power-of-2 NUM_FU stays exact.
    function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(off);
        if (sum >= FU_CNT) sum = sum - FU_CNT;
        return sum[PTR_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == LAST_FU) ? '0 : idx + PTR_W'(1);
    endfunction

    logic [ROB_IDX_LEN-1:0] rob_arr [NUM_FU];
    logic [XLEN-1:0]        val_arr [NUM_FU];

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
        assign rob_arr[g] = fu_rob_idx[g*ROB_IDX_LEN +: ROB_IDX_LEN];
        assign val_arr[g] = fu_value[g*XLEN +: XLEN];
    end

    logic             grant_en;
    logic             hit0, hit1;
    logic [PTR_W-1:0] sel0, sel1, cand;

    assign grant_en = reset & ~squash;

    always_comb begin
        hit0     = 1'b0;
        hit1     = 1'b0;
        sel0     = '0;
        sel1     = '0;
        cand     = '0;
        fu_ready = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            cand = scan_idx(rr_ptr, i);
            if (grant_en && fu_valid[cand]) begin
                if (!hit0) begin
                    hit0 = 1'b1;
                    sel0 = cand;
                end else if (!hit1) begin
                    hit1 = 1'b1;
                    sel1 = cand;
                end
            end
        end
        if (hit0) fu_ready[sel0] = 1'b1;
        if (hit1) fu_ready[sel1] = 1'b1;
    end

    logic [1:0]               vld_p1;
    logic [2*ROB_IDX_LEN-1:0] rob_p1;
    logic [2*XLEN-1:0]        val_p1;
    logic [1:0]               wp_p1;
    logic [PTR_W-1:0]         ptr_q;

    // Stage p1: registered CDB broadcast, consumed by ROB/RS next cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p1 <= '0;
            rob_p1 <= '0;
            val_p1 <= '0;
            wp_p1  <= '0;
            ptr_q  <= '0;
        end else begin
            vld_p1 <= {hit1, hit0};
            if (hit0) begin
                rob_p1[0 +: ROB_IDX_LEN] <= rob_arr[sel0];
                val_p1[0 +: XLEN]        <= val_arr[sel0];
                wp_p1[0]                 <= fu_wrong_pred[sel0];
            end
            if (hit1) begin
                rob_p1[ROB_IDX_LEN +: ROB_IDX_LEN] <= rob_arr[sel1];
                val_p1[XLEN +: XLEN]               <= val_arr[sel1];
                wp_p1[1]                           <= fu_wrong_pred[sel1];
            end
            if (hit1)      ptr_q <= next_ptr(sel1);
            else if (hit0) ptr_q <= next_ptr(sel0);
        end
    end

    assign cdb_valid      = vld_p1;
    assign cdb_rob_idx    = rob_p1;
    assign cdb_value      = val_p1;
    assign cdb_wrong_pred = wp_p1;
    assign rr_ptr         = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (NUM_FU=4): a round-robin reference model
// predicts each cycle's grants and the CDB contents one edge later.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int RL = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            squash;
    logic [N-1:0]    fu_valid;
    logic [N*RL-1:0] fu_rob_idx;
    logic [N*XL-1:0] fu_value;
    logic [N-1:0]    fu_wrong_pred;
    logic [N-1:0]    fu_ready;
    logic [1:0]      cdb_valid;
    logic [2*RL-1:0] cdb_rob_idx;
    logic [2*XL-1:0] cdb_value;
    logic [1:0]      cdb_wrong_pred;
    logic [1:0]      rr_ptr;

    cdb_arbiter #(.NUM_FU(N), .XLEN(XL), .ROB_IDX_LEN(RL)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_valid(fu_valid), .fu_rob_idx(fu_rob_idx), .fu_value(fu_value),
        .fu_wrong_pred(fu_wrong_pred), .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value),
        .cdb_wrong_pred(cdb_wrong_pred), .rr_ptr(rr_ptr)
    );

    always #5 clock = ~clock;

    logic [RL-1:0] rob_a [N];
    logic [XL-1:0] val_a [N];
    logic          wp_a  [N];

    always_comb begin
        fu_rob_idx    = '0;
        fu_value      = '0;
        fu_wrong_pred = '0;
        for (int i = 0; i < N; i++) begin
            fu_rob_idx[i*RL +: RL] = rob_a[i];
            fu_value[i*XL +: XL]   = val_a[i];
            fu_wrong_pred[i]       = wp_a[i];
        end
    end

    typedef struct {
        logic [1:0]    v;
        logic [RL-1:0] r0, r1;
        logic [XL-1:0] d0, d1;
        logic          w0, w1;
        logic [1:0]    p;
        logic          rst;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_ptr  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_fu(input int i, input logic [RL-1:0] r, input logic [XL-1:0] d, input logic w);
        rob_a[i] = r;
        val_a[i] = d;
        wp_a[i]  = w;
    endtask

    // One clock: predict grants, check fu_ready, push expectation, then pop and compare after the edge.
    task automatic step(input logic [N-1:0] v, input logic sq, input logic rs);
        exp_t       e, g;
        logic [N-1:0] rdy;
        int         n, j, last;
        fu_valid = v;
        squash   = sq;
        reset    = rs;
        #1;
        rdy  = '0;
        n    = 0;
        last = -1;
        e.v  = 2'b00;
        e.r0 = '0; e.r1 = '0; e.d0 = '0; e.d1 = '0; e.w0 = 1'b0; e.w1 = 1'b0;
        e.rst = !rs;
        if (rs && !sq) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (v[j] && n < 2) begin
                    rdy[j] = 1'b1;
                    if (n == 0) begin
                        e.v[0] = 1'b1; e.r0 = rob_a[j]; e.d0 = val_a[j]; e.w0 = wp_a[j];
                    end else begin
                        e.v[1] = 1'b1; e.r1 = rob_a[j]; e.d1 = val_a[j]; e.w1 = wp_a[j];
                    end
                    last = j;
                    n++;
                end
            end
        end
        if (!rs)            m_ptr = 0;
        else if (last >= 0) m_ptr = (last + 1) % N;
        e.p = 2'(m_ptr);
        check("fu_ready", fu_ready, rdy);
        sb.push_back(e);
        @(posedge clock);
        #1;
        check("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        g = sb.pop_front();
        check("cdb_valid", cdb_valid, g.v);
        check("rr_ptr", rr_ptr, g.p);
        if (g.v[0] || g.rst) begin
            check("rob0", cdb_rob_idx[0 +: RL], g.r0);
            check("val0", cdb_value[0 +: XL], g.d0);
            check("wp0", cdb_wrong_pred[0], g.w0);
        end
        if (g.v[1] || g.rst) begin
            check("rob1", cdb_rob_idx[RL +: RL], g.r1);
            check("val1", cdb_value[XL +: XL], g.d1);
            check("wp1", cdb_wrong_pred[1], g.w1);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_fu(i, 5'(10 + i), 32'(1000 * (i + 1)), 1'b0);
        fu_valid = '0;
        squash   = 1'b0;
        reset    = 1'b0;

        // reset held with all FUs requesting, then release grants FU0/FU1
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);

        // single request from FU2
        set_fu(2, 5'd7, 32'd156, 1'b0);
        step(4'b0100, 1'b0, 1'b1);

        // wrap-around from rr_ptr=3
        step(4'b1001, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // bring rr_ptr back to 0, then full contention
        step(4'b1000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) set_fu(i, 5'(4 * c + i), 32'(100 * c + i + 1), 1'(i[0]));
            step(4'b1111, 1'b0, 1'b1);
        end

        // squash while CDB holds two results; then FU0/FU1 granted
        step(4'b0011, 1'b1, 1'b1);
        step(4'b0011, 1'b0, 1'b1);

        // mispredict propagation, then reset mid-stream
        set_fu(2, 5'd2, 32'hDEAD_BEEF, 1'b1);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);

        // randomized traffic including occasional squash
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++)
                set_fu(i, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Completion-side scheduler for the ROB in the 2-way superscalar core.
- Shares the two ROB completion ports (the common data bus, CDB) among NUM_FU functional units.
- Each cycle it grants up to two FU requests in round-robin order and registers the winners onto CDB slots 0/1. The ROB and RS consume those slots the next cycle.
- Squash-aware: flushes in-flight broadcasts on branch mispredict recovery.

Parameters:
NUM_FU, 4, number of requesting functional units (2..8)
XLEN, 32, result data width
ROB_IDX_LEN, 5, ROB entry index width

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
squash  input  1  ROB squash-at-head; flush CDB and block grants this cycle
fu_valid  input  NUM_FU  per-FU completion request
fu_rob_idx  input  NUM_FU*ROB_IDX_LEN  packed ROB entry of each FU result, FU i at [i*ROB_IDX_LEN +: ROB_IDX_LEN]
fu_value  input  NUM_FU*XLEN  packed result value, FU i at [i*XLEN +: XLEN]
fu_wrong_pred  input  NUM_FU  branch result mispredicted
fu_ready  output  NUM_FU  combinational grant; request accepted at this edge
cdb_valid  output  2  registered CDB slot valid
cdb_rob_idx  output  2*ROB_IDX_LEN  registered ROB index per slot
cdb_value  output  2*XLEN  registered value per slot
cdb_wrong_pred  output  2  registered mispredict flag per slot
rr_ptr  output  $clog2(NUM_FU)  current round-robin start pointer (debug/verification)

Behaviour:
- Reset (reset==0 at edge): cdb_valid=0, cdb_rob_idx=0, cdb_value=0, cdb_wrong_pred=0, rr_ptr=0. fu_ready is forced 0 while reset==0. Reset mid-operation drops any granted-but-unbroadcast data.
- Handshake: an FU holds fu_valid and its data stable until it sees fu_ready=1. Transfer occurs at the edge where fu_valid && fu_ready. Ungranted requests persist with no loss.
- Grant (combinational, squash==0, reset==1):
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - First valid FU takes slot 0; second valid FU takes slot 1.
  - At most 2 grants per cycle; fu_ready is one-hot per granted FU.
- CDB register, 1-cycle latency:
  - At the edge, slot k loads the granted FU's rob_idx, value and wrong_pred, with cdb_valid[k]=1.
  - Ungranted slots get cdb_valid[k]=0; their data fields keep their old values (don't-care).
  - One grant uses slot 0 only. Slot 1 is never valid without slot 0.
- rr_ptr update: on any grant, rr_ptr <= (last granted index + 1) mod NUM_FU. With no grant it is unchanged. Fairness bound: every continuously-valid FU is granted within ceil(NUM_FU/2) cycles.
- Squash (squash==1):
  - fu_ready=0 for all FUs.
  - At the edge, cdb_valid <= 0 and rr_ptr is unchanged.
  - Pending FU requests stay pending; FUs/RS clear them by their own squash handling.
- Squash with reset==0: reset wins.
- Simultaneous requests from all NUM_FU: exactly 2 granted per cycle, rotating. Wrap-around from FU NUM_FU-1 to FU 0 within the same cycle is legal.
- No back-pressure from the ROB; the CDB is always accepted.
- Width rules:
  - The rr_ptr mod is exact for non-power-of-2 NUM_FU (explicit wrap compare, not truncation).
  - Packed port slicing is LSB-first by index.

Test Plan (NUM_FU=4):
- Reset: reset=0 for 2 cycles with fu_valid=4'b1111 -> fu_ready=0, cdb_valid=0, rr_ptr=0. After reset=1, first edge grants FU0 and FU1.
- Single request: fu_valid=4'b0100, rob_idx=7, value=156 -> fu_ready=4'b0100. Next cycle cdb_valid=2'b01, cdb_rob_idx slot0=7, value=156. rr_ptr=3.
- Full contention rotation: fu_valid=4'b1111 held 4 cycles with rr_ptr=0 -> grants {0,1},{2,3},{0,1},{2,3}. rr_ptr sequence 2,0,2,0. CDB data matches each granted FU.
- Wrap-around: rr_ptr=3, fu_valid=4'b1001 -> FU3 in slot 0, FU0 in slot 1. rr_ptr becomes 1.
- Squash: CDB holding 2 valid results, squash=1 with fu_valid=4'b0011 -> fu_ready=0. Next cycle cdb_valid=0, rr_ptr unchanged. After squash drops, FU0/FU1 are granted.
- Mispredict propagation: FU2 valid with wrong_pred=1, rob_idx=2 -> cdb_wrong_pred slot0=1, cdb_rob_idx=2 one cycle later. Mid-stream reset=0 clears cdb_valid at that edge.
